// File: rtl/leak_gain_restore_q31.sv
// Q31 gain-restore divider: out = trunc(in_data * COEF_ONE / coef_in), undoing the leak multiply.
// Radix-2 restoring division, one quotient bit per clock, one sample in flight.
module leak_gain_restore_q31 #(
    parameter logic [31:0] COEF_ONE = 32'h7FFFFFFF,
    parameter int          ITER     = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [31:0] in_data,
    input  logic signed [31:0] coef_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [31:0] out_data,
    output logic               out_sat,
    output logic               out_err
);

    localparam int CNT_W = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, DIV, FIX, HOLD} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [63:0]        dividend;
    logic [30:0]        divisor;
    logic [63:0]        quot;
    logic [31:0]        rem;
    logic               neg, err;
    logic signed [31:0] res;
    logic               res_sat, res_err;

    logic [31:0]        in_mag;
    logic               coef_bad;
    logic [32:0]        div_rs;
    logic [32:0]        div_diff;
    logic               div_ge;
    logic [32:0]        fix_val;

    // Clamp a 64-bit quotient magnitude into signed Q31; bit 32 flags saturation.
    function automatic logic [32:0] sat_q31(input logic [63:0] mag, input logic is_neg);
        logic [31:0] r;
        if (!is_neg) begin
            if (mag > 64'h0000_0000_7FFF_FFFF) return {1'b1, 32'h7FFFFFFF};
            r = mag[31:0];
        end else begin
            if (mag > 64'h0000_0000_8000_0000) return {1'b1, 32'h80000000};
            r = ~mag[31:0] + 32'd1;
        end
        return {1'b0, r};
    endfunction

    assign in_mag   = in_data[31] ? (~$unsigned(in_data) + 32'd1) : $unsigned(in_data);
    assign coef_bad = (coef_in <= 32'sd0);
    assign div_rs   = {rem, dividend[63]};
    assign div_diff = div_rs - {2'b00, divisor};
    assign div_ge   = (div_rs >= {2'b00, divisor});
    assign fix_val  = err ? {1'b1, (neg ? 32'h80000000 : 32'h7FFFFFFF)} : sat_q31(quot, neg);
    assign in_ready = (state == IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = coef_bad ? FIX : DIV;
            DIV:  if (cnt == CNT_W'(ITER - 1)) state_nxt = FIX;
            FIX:  state_nxt = HOLD;
            HOLD: if (out_valid && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            dividend  <= '0;
            divisor   <= '0;
            quot      <= '0;
            rem       <= '0;
            neg       <= 1'b0;
            err       <= 1'b0;
            res       <= '0;
            res_sat   <= 1'b0;
            res_err   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    dividend <= {32'd0, in_mag} * {32'd0, COEF_ONE};
                    divisor  <= coef_in[30:0];
                    neg      <= in_data[31];
                    err      <= coef_bad;
                    quot     <= '0;
                    rem      <= '0;
                    cnt      <= '0;
                end
                // One restoring step per clock: shift in a dividend bit, subtract when it fits.
                DIV: begin
                    dividend <= {dividend[62:0], 1'b0};
                    quot     <= {quot[62:0], div_ge};
                    rem      <= div_ge ? div_diff[31:0] : div_rs[31:0];
                    cnt      <= cnt + 1'b1;
                end
                FIX: begin
                    res     <= fix_val[31:0];
                    res_sat <= fix_val[32];
                    res_err <= err;
                end
                // Outputs load on the first HOLD cycle and stay put until taken.
                HOLD: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= res;
                        out_sat   <= res_sat;
                        out_err   <= res_err;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_leak_gain_restore_q31.sv
// Directed-vector bench for leak_gain_restore_q31: values, flags, latency, backpressure, reset abort.
module tb_leak_gain_restore_q31;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] coef_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sat;
    logic        out_err;

    int checks = 0;
    int failures = 0;

    localparam logic [31:0] LEAK = 32'h7FDF3B63;

    always #5 clk = ~clk;

    leak_gain_restore_q31 dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .coef_in  (coef_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sat  (out_sat),
        .out_err  (out_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // Drive one sample at a negedge while in_ready; return after the accepting edge (+1).
    task automatic accept(input logic [31:0] d, input logic [31:0] c);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        in_data  = d;
        coef_in  = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges from the accept edge until out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 300);
    endtask

    task automatic run(input string tag, input logic [31:0] d, input logic [31:0] c,
                       input logic [31:0] exp_d, input logic exp_s, input logic exp_e,
                       input int exp_lat);
        int lat;
        accept(d, c);
        wait_valid(lat);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_data"}, out_data, exp_d);
        chk({tag, "_sat"}, {31'd0, out_sat}, {31'd0, exp_s});
        chk({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_e});
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_vld_drop"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_rdy_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        logic [31:0] held;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        coef_in = '0;
        out_ready = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_flags", {30'd0, out_sat, out_err}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Abort mid-division: reset between edges T+29 and T+30.
        accept(32'd12345, LEAK);
        repeat (29) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_out_data", out_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run("post_rst", 32'd1000, LEAK, 32'd1001, 1'b0, 1'b0, 66);

        run("pos_max", 32'h7FDF3B63, LEAK, 32'h7FFFFFFF, 1'b0, 1'b0, 66);
        run("neg_max", 32'h8020C49D, LEAK, 32'h80000001, 1'b0, 1'b0, 66);
        run("pos_sat", 32'h7FFFFFFF, LEAK, 32'h7FFFFFFF, 1'b1, 1'b0, 66);
        run("neg_sat", 32'h80000000, LEAK, 32'h80000000, 1'b1, 1'b0, 66);
        run("neg_trunc", 32'hFFFFFC18, LEAK, 32'hFFFFFC17, 1'b0, 1'b0, 66);
        run("unity", 32'd100, 32'h7FFFFFFF, 32'd100, 1'b0, 1'b0, 66);
        run("zero_in", 32'd0, LEAK, 32'd0, 1'b0, 1'b0, 66);
        run("err_zero", 32'd5, 32'd0, 32'h7FFFFFFF, 1'b1, 1'b1, 2);
        run("err_neg", 32'hFFFFFFFB, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b1, 2);

        // Backpressure: hold off out_ready while a new sample waits upstream.
        accept(32'd2000, LEAK);
        wait_valid(lat);
        chk("bp_lat", 32'(lat), 32'd66);
        chk("bp_data", out_data, 32'd2002);
        held = out_data;
        @(negedge clk);
        in_data  = 32'd1000;
        coef_in  = LEAK;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_data", out_data, held);
            chk("bp_hold_vld", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_hs_vld", {31'd0, out_valid}, 32'd0);
        chk("bp_hs_rdy", {31'd0, in_ready}, 32'd1);
        chk("bp_keep_data", out_data, held);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("b2b_taken", {31'd0, in_ready}, 32'd0);
        wait_valid(lat);
        chk("b2b_lat", 32'(lat), 32'd66);
        chk("b2b_data", out_data, 32'd1001);
        chk("b2b_flags", {30'd0, out_sat, out_err}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/leak_gain_restore_q31.md
Name: leak_gain_restore_q31

Overview:
- Sequential Q31 gain-restore divider: out = trunc(in_data * COEF_ONE / coef_in), the inverse of the fixed 0.999 leak multiply used in the noise-cancelling filter path.
- Restores adaptive-filter / accumulator samples scaled by a leak coefficient before error computation or logging.
- Iterative restoring division, one quotient bit per clock, with valid/ready on both sides.

Parameters:
- COEF_ONE, 32'h7FFFFFFF, Q31 unity; numerator multiplier.
- ITER, 64, division iterations (dividend width); fixed at 64 for a 32-bit datapath.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  32  signed Q31 sample.
- coef_in  in  32  signed Q31 leak coefficient (e.g. 32'h7FDF3B63 = 0.999); sampled with in_data.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  32  signed Q31 restored sample.
- out_sat  out  1  result was clamped (valid with out_valid).
- out_err  out  1  coef_in <= 0 at accept (valid with out_valid).

Behaviour:
- Reset: async and active-high. Interface is decided: one clock, asynchronous active-high reset.
  - Reset state is IDLE; in_ready=1, out_valid=0, out_data=0, out_sat=0, out_err=0.
  - Internal dividend, divisor, quotient and remainder clear to 0.
  - Reset mid-operation aborts the division; the partial result is discarded and never presented.
- FSM: IDLE -> DIV -> FIX -> HOLD -> IDLE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid && in_ready at edge T.
  - Capture sign(in_data) and sign(coef_in).
  - Capture |in_data| as a 32-bit unsigned value; -2^31 gives 2^31.
  - Dividend = |in_data| * COEF_ONE (64-bit unsigned); divisor = coef_in[30:0].
  - If coef_in <= 0, set err and go to FIX directly; otherwise go to DIV.
- DIV:
  - 64 cycles. Each cycle: shift remainder left by one and take in the next dividend MSB.
  - If remainder >= divisor, subtract it and shift in quotient bit 1; else shift in 0.
  - in_ready=0 throughout.
- FIX (1 cycle):
  - Apply sign: negate if in_data < 0. Rounding is truncation toward zero, matching signed '/' semantics.
  - Saturate: result > 2^31-1 gives 32'h7FFFFFFF; result < -2^31 gives 32'h80000000. Set sat in either case.
  - err case: out_data = 7FFFFFFF if in_data >= 0, else 80000000; sat=1, err=1.
- HOLD:
  - out_valid=1. out_data, out_sat and out_err are stable until out_ready.
  - On out_valid && out_ready: go to IDLE, drop out_valid, keep out_data at its last value.
- Latency:
  - Normal case: out_valid rises at T+66 (64 DIV + 1 FIX + register).
  - err case: out_valid rises at T+2.
- Throughput: one sample in flight. in_ready=0 from T+1 until the cycle after the output handshake; no overlap.
- in_data = 0 gives 0 after full latency (no early exit; constant latency).
- coef_in = COEF_ONE gives out_data = in_data exactly.
- out_ready held high while out_valid rises: the handshake completes in that first valid cycle.
- in_valid asserted while busy is ignored; the upstream must hold it.

Test Plan:
- Reset asserted asynchronously mid-DIV (cycle T+30) -> outputs immediately 0/in_ready=1; next sample in=1000, coef=7FDF3B63 -> out_data=1001 (0x3E9), sat=0, err=0, out_valid exactly at T+66.
- in=0x7FDF3B63, coef=0x7FDF3B63 -> out=0x7FFFFFFF, sat=0; in=0x8020C49D same coef -> out=0x80000001, sat=0.
- in=0x7FFFFFFF, coef=0x7FDF3B63 -> out=0x7FFFFFFF, sat=1; in=0x80000000 -> out=0x80000000, sat=1.
- in=-1000 (0xFFFFFC18), coef=0x7FDF3B63 -> out=-1001 (0xFFFFFC17), truncation toward zero; in=100, coef=0x7FFFFFFF -> out=100.
- coef=0, in=5 -> out_valid at T+2, out=0x7FFFFFFF, sat=1, err=1; coef=0xFFFFFFFF, in=-5 -> out=0x80000000, err=1.
- Backpressure: out_ready low for 10 cycles after out_valid -> out_data stable, in_ready=0, new in_valid ignored; out_ready high -> handshake, in_ready=1 the next cycle, back-to-back sample accepted.
